// File: rtl/snn_seq_pkg.sv
// Shared types and defaults for the stochastic forward-propagation sequencer.
package snn_seq_pkg;

    localparam int unsigned DEF_N_OUT        = 5;
    localparam int unsigned DEF_WINDOW       = 256;
    localparam int unsigned DEF_SETTLE       = 3;
    localparam int unsigned DEF_TRAIN_CYCLES = 256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETTLE,
        S_SAMPLE,
        S_TRAIN,
        S_DONE
    } seq_state_t;

    // Bits needed to hold a count that can reach n inclusive
    function automatic int unsigned cw_of(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m == 0) ? 1 : m;
    endfunction

endpackage

// File: rtl/snn_argmax.sv
// Combinational N-way argmax over packed counts; ties resolve to the lowest index.
module snn_argmax #(
    parameter int unsigned N_OUT = 5,
    parameter int unsigned CW    = 9,
    parameter int unsigned IW    = 3
) (
    input  logic [N_OUT*CW-1:0] i_counts,
    output logic [IW-1:0]       o_idx
);

    logic [CW-1:0] w_best_val;

    // Strict greater-than keeps the earliest index on equal counts
    always_comb begin
        w_best_val = i_counts[0 +: CW];
        o_idx      = '0;
        for (int k = 1; k < int'(N_OUT); k++) begin
            if (i_counts[k*CW +: CW] > w_best_val) begin
                w_best_val = i_counts[k*CW +: CW];
                o_idx      = IW'(k);
            end
        end
    end

endmodule

// File: rtl/snn_fwd_sequencer.sv
// Inference-window sequencer: clear, settle, sample output ones, optional train hold, argmax.
module snn_fwd_sequencer
    import snn_seq_pkg::*;
#(
    parameter int unsigned N_OUT        = DEF_N_OUT,
    parameter int unsigned WINDOW       = DEF_WINDOW,
    parameter int unsigned SETTLE       = DEF_SETTLE,
    parameter int unsigned TRAIN_CYCLES = DEF_TRAIN_CYCLES,
    parameter int unsigned CW           = cw_of(DEF_WINDOW),
    parameter int unsigned IW           = $clog2(DEF_N_OUT)
) (
    input  logic                CLK,
    input  logic                INIT,
    input  logic                start,
    input  logic                train_en,
    input  logic                abort,
    input  logic [N_OUT-1:0]    a_out,
    output logic                fp_clear,
    output logic                training_flag,
    output logic                busy,
    output logic                done,
    output logic [N_OUT*CW-1:0] counts,
    output logic [IW-1:0]       class_idx,
    output logic                class_valid
);

    localparam int unsigned PW = max3($clog2(SETTLE), $clog2(WINDOW), $clog2(TRAIN_CYCLES));

    seq_state_t          r_state;
    logic [PW-1:0]       r_phase;
    logic                r_train;
    logic [N_OUT*CW-1:0] r_counts;
    logic [IW-1:0]       w_argmax;

    assign counts = r_counts;

    snn_argmax #(
        .N_OUT (N_OUT),
        .CW    (CW),
        .IW    (IW)
    ) u_argmax (
        .i_counts (r_counts),
        .o_idx    (w_argmax)
    );

    // Phase counter reloads with (length-1) on each state entry and exits at zero
    always_ff @(posedge CLK or posedge INIT) begin
        if (INIT) begin
            r_state       <= S_IDLE;
            r_phase       <= '0;
            r_train       <= 1'b0;
            r_counts      <= '0;
            fp_clear      <= 1'b0;
            training_flag <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            class_idx     <= '0;
            class_valid   <= 1'b0;
        end else begin
            fp_clear <= 1'b0;
            done     <= 1'b0;
            if (r_state != S_IDLE && abort) begin
                r_state       <= S_IDLE;
                busy          <= 1'b0;
                training_flag <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            r_state     <= S_CLEAR;
                            r_train     <= train_en;
                            r_counts    <= '0;
                            fp_clear    <= 1'b1;
                            busy        <= 1'b1;
                            class_valid <= 1'b0;
                        end
                    end
                    S_CLEAR: begin
                        r_state <= S_SETTLE;
                        r_phase <= PW'(SETTLE - 1);
                    end
                    S_SETTLE: begin
                        if (r_phase == '0) begin
                            r_state <= S_SAMPLE;
                            r_phase <= PW'(WINDOW - 1);
                        end else begin
                            r_phase <= r_phase - PW'(1);
                        end
                    end
                    S_SAMPLE: begin
                        for (int k = 0; k < int'(N_OUT); k++) begin
                            r_counts[k*CW +: CW] <= r_counts[k*CW +: CW] + CW'(a_out[k]);
                        end
                        if (r_phase == '0) begin
                            if (r_train) begin
                                r_state       <= S_TRAIN;
                                r_phase       <= PW'(TRAIN_CYCLES - 1);
                                training_flag <= 1'b1;
                            end else begin
                                r_state <= S_DONE;
                                done    <= 1'b1;
                            end
                        end else begin
                            r_phase <= r_phase - PW'(1);
                        end
                    end
                    S_TRAIN: begin
                        if (r_phase == '0) begin
                            r_state       <= S_DONE;
                            training_flag <= 1'b0;
                            done          <= 1'b1;
                        end else begin
                            r_phase <= r_phase - PW'(1);
                        end
                    end
                    S_DONE: begin
                        r_state     <= S_IDLE;
                        busy        <= 1'b0;
                        class_idx   <= w_argmax;
                        class_valid <= 1'b1;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_snn_fwd_sequencer.sv
// Bench for snn_fwd_sequencer: per-scenario tasks checked against a cycle-indexed ones-count model.
module tb_snn_fwd_sequencer;

    localparam int N_OUT        = 5;
    localparam int WINDOW       = 256;
    localparam int SETTLE       = 3;
    localparam int TRAIN_CYCLES = 256;
    localparam int CW           = 9;
    localparam int IW           = 3;

    logic                CLK = 1'b0;
    logic                INIT;
    logic                start;
    logic                train_en;
    logic                abort;
    logic [N_OUT-1:0]    a_out;
    logic                fp_clear;
    logic                training_flag;
    logic                busy;
    logic                done;
    logic [N_OUT*CW-1:0] counts;
    logic [IW-1:0]       class_idx;
    logic                class_valid;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    snn_fwd_sequencer #(
        .N_OUT        (N_OUT),
        .WINDOW       (WINDOW),
        .SETTLE       (SETTLE),
        .TRAIN_CYCLES (TRAIN_CYCLES),
        .CW           (CW),
        .IW           (IW)
    ) dut (
        .CLK           (CLK),
        .INIT          (INIT),
        .start         (start),
        .train_en      (train_en),
        .abort         (abort),
        .a_out         (a_out),
        .fp_clear      (fp_clear),
        .training_flag (training_flag),
        .busy          (busy),
        .done          (done),
        .counts        (counts),
        .class_idx     (class_idx),
        .class_valid   (class_valid)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One full inference; cycle c means the c-th cycle after the accepting edge
    task automatic run_inference(input string name, input logic tr, input int mode,
                                 input logic [N_OUT-1:0] pat);
        int mcnt[N_OUT];
        int c, lat, tf, tf_first, exp_lat, exp_idx, best;
        logic [N_OUT-1:0] v;
        logic fp_extra;
        logic [N_OUT*CW-1:0] exp_counts;
        for (int k = 0; k < N_OUT; k++) mcnt[k] = 0;
        exp_lat = 2 + SETTLE + WINDOW + (tr ? TRAIN_CYCLES : 0);
        start = 1'b1; train_en = tr; abort = 1'b0;
        tick();
        start = 1'b0; train_en = ~tr;
        total++;
        if (fp_clear !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s fp_clear/busy at t+1: got %b/%b want 1/1", name, fp_clear, busy);
        end
        c = 1; lat = -1; tf = 0; tf_first = -1; fp_extra = 1'b0;
        while (c <= exp_lat + 20) begin
            case (mode)
                0:       v = pat;
                1:       v = 5'b01000 | ((c % 2 == 1) ? 5'b00010 : 5'b00000);
                default: v = N_OUT'($urandom);
            endcase
            a_out = v;
            if (c >= 2 + SETTLE && c <= 1 + SETTLE + WINDOW)
                for (int k = 0; k < N_OUT; k++) mcnt[k] += int'(v[k]);
            if (training_flag === 1'b1) begin
                tf++;
                if (tf_first < 0) tf_first = c;
            end
            if (c > 1 && fp_clear !== 1'b0) fp_extra = 1'b1;
            if (done === 1'b1) begin
                lat = c;
                break;
            end
            tick();
            c++;
        end
        for (int k = 0; k < N_OUT; k++) exp_counts[k*CW +: CW] = CW'(mcnt[k]);
        best = mcnt[0]; exp_idx = 0;
        for (int k = 1; k < N_OUT; k++)
            if (mcnt[k] > best) begin best = mcnt[k]; exp_idx = k; end
        total++;
        if (lat != exp_lat) begin
            bad++;
            $display("FAIL %s done latency: got %0d want %0d", name, lat, exp_lat);
        end
        total++;
        if (tf != (tr ? TRAIN_CYCLES : 0)) begin
            bad++;
            $display("FAIL %s training_flag cycles: got %0d want %0d", name, tf, tr ? TRAIN_CYCLES : 0);
        end
        if (tr) begin
            total++;
            if (tf_first != 2 + SETTLE + WINDOW) begin
                bad++;
                $display("FAIL %s training_flag start: got %0d want %0d", name, tf_first, 2 + SETTLE + WINDOW);
            end
        end
        total++;
        if (fp_extra !== 1'b0) begin
            bad++;
            $display("FAIL %s fp_clear extra pulse: got %b want 0", name, fp_extra);
        end
        total++;
        if (counts !== exp_counts) begin
            bad++;
            $display("FAIL %s counts: got %h want %h", name, counts, exp_counts);
        end
        a_out = '0;
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || class_valid !== 1'b1 || class_idx !== IW'(exp_idx)) begin
            bad++;
            $display("FAIL %s result: got done=%b busy=%b valid=%b idx=%0d want 0 0 1 %0d",
                     name, done, busy, class_valid, class_idx, exp_idx);
        end
    endtask

    task automatic test_reset();
        INIT = 1'b1; start = 1'b0; train_en = 1'b0; abort = 1'b0; a_out = '0;
        repeat (3) tick();
        total++;
        if ({fp_clear, training_flag, busy, done, class_valid} !== 5'b0 ||
            counts !== '0 || class_idx !== '0) begin
            bad++;
            $display("FAIL reset outputs: got %b counts=%h idx=%0d want all zero",
                     {fp_clear, training_flag, busy, done, class_valid}, counts, class_idx);
        end
        #2 INIT = 1'b0;
        tick();
    endtask

    task automatic test_start_abort_idle();
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        total++;
        if (busy !== 1'b0 || fp_clear !== 1'b0) begin
            bad++;
            $display("FAIL start_abort_idle: got busy=%b fp_clear=%b want 0 0", busy, fp_clear);
        end
    endtask

    task automatic test_abort();
        int c, ab_c, exp_n;
        logic seen;
        logic [N_OUT*CW-1:0] exp_counts;
        a_out = 5'b11111; train_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 1;
        ab_c = 2 + SETTLE + 99;
        while (c < ab_c) begin
            start = (c == 10);
            tick();
            c++;
        end
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_n = ab_c - (2 + SETTLE);
        for (int k = 0; k < N_OUT; k++) exp_counts[k*CW +: CW] = CW'(exp_n);
        total++;
        if (busy !== 1'b0 || class_valid !== 1'b0 || counts !== exp_counts) begin
            bad++;
            $display("FAIL abort state: got busy=%b valid=%b counts=%h want 0 0 %h",
                     busy, class_valid, counts, exp_counts);
        end
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done !== 1'b0 || busy !== 1'b0 || class_valid !== 1'b0) seen = 1'b1;
            tick();
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL abort aftermath: got activity=%b want 0", seen);
        end
        a_out = '0;
    endtask

    task automatic test_init_mid_train();
        int c;
        a_out = 5'b00110; train_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 1;
        while (c < 2 + SETTLE + WINDOW + 50) begin
            tick();
            c++;
        end
        total++;
        if (training_flag !== 1'b1) begin
            bad++;
            $display("FAIL init_mid_train flag before reset: got %b want 1", training_flag);
        end
        #2 INIT = 1'b1;
        #1;
        total++;
        if ({fp_clear, training_flag, busy, done, class_valid} !== 5'b0 ||
            counts !== '0 || class_idx !== '0) begin
            bad++;
            $display("FAIL init_mid_train outputs: got %b counts=%h idx=%0d want all zero",
                     {fp_clear, training_flag, busy, done, class_valid}, counts, class_idx);
        end
        #1 INIT = 1'b0;
        tick();
        a_out = '0;
        run_inference("after_init", 1'b1, 0, 5'b00100);
    endtask

    task automatic test_back_to_back();
        run_inference("b2b_first", 1'b0, 2, '0);
        run_inference("b2b_second", 1'b0, 0, 5'b10000);
    endtask

    initial begin
        test_reset();
        run_inference("basic", 1'b0, 0, 5'b00001);
        run_inference("alternate", 1'b0, 1, '0);
        run_inference("train", 1'b1, 0, 5'b00010);
        run_inference("tie", 1'b0, 0, 5'b10100);
        run_inference("random0", 1'b0, 2, '0);
        run_inference("random1", 1'b1, 2, '0);
        test_start_abort_idle();
        test_abort();
        test_init_mid_train();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snn_fwd_sequencer.md
# snn_fwd_sequencer

Sequencer for the stochastic fully connected network's forward-propagation datapath. Runs one inference window on request: clears the layer pipeline, waits for the stochastic pipeline to fill, counts output-layer ones over a fixed window, and optionally holds the training flag for the backprop phase. Produces per-output counts, an argmax class and a done pulse. Sits between the host/test controller and the forward-propagation block; drives that block's clear and training-flag inputs.

## Interface
- N_OUT, 5, output-layer neurons (width of the monitored activation bus)
- WINDOW, 256, sample cycles per inference
- SETTLE, 3, pipeline fill cycles discarded after clear (matches layer memory depth)
- TRAIN_CYCLES, 256, cycles the training flag is held when training is enabled
- CW, $clog2(WINDOW+1), count width
- CLK  in  1  single clock, rising edge
- INIT  in  1  asynchronous, active-high reset
- start  in  1  begin an inference; sampled only in IDLE
- train_en  in  1  latched with start; enables TRAIN phase
- abort  in  1  return to IDLE from any state
- a_out  in  N_OUT  output-layer stochastic bits from the datapath
- fp_clear  out  1  one-cycle synchronous clear to the datapath
- training_flag  out  1  drives the datapath training flag
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- counts  out  N_OUT*CW  packed ones-counts, neuron k at [k*CW +: CW]
- class_idx  out  $clog2(N_OUT)  index of largest count
- class_valid  out  1  class_idx/counts valid; cleared on next accepted start

## Operation
- States: IDLE, CLEAR, SETTLE, SAMPLE, TRAIN, DONE.
- IDLE: start=1 and abort=0 -> CLEAR; train_en latched.
- CLEAR: 1 cycle; fp_clear=1; counts zeroed; class_valid cleared -> SETTLE.
- SETTLE: SETTLE cycles; a_out ignored -> SAMPLE.
- SAMPLE: WINDOW cycles; each cycle count[k] += a_out[k]. Max value WINDOW, fits CW; no saturation logic. Then: latched train_en -> TRAIN, else DONE.
- TRAIN: TRAIN_CYCLES cycles; training_flag=1 -> DONE.
- DONE: 1 cycle; done=1; class_idx registered from final counts, class_valid=1 -> IDLE.
- Argmax: strictly-greater comparison, lowest index wins ties; all-zero counts -> class_idx=0.
- abort=1 in any non-IDLE state: next state IDLE, no done pulse, training_flag drops next edge, class_valid stays 0, counts hold partial values.
- start while busy: ignored (no queuing). start and abort both high in IDLE: abort wins.
- train_en changes after start: no effect on the running inference.

## Timing
- Reset (INIT=1): state IDLE; fp_clear, training_flag, busy, done, class_valid = 0; counts = 0; class_idx = 0. Reset mid-operation: same, immediately, no done.
- All outputs registered.
- start accepted at edge t -> fp_clear high cycle t+1; first counted sample at cycle t+2+SETTLE; last at t+1+SETTLE+WINDOW.
- Latency start-edge -> done high: 2+SETTLE+WINDOW cycles without training; +TRAIN_CYCLES with training.
- Earliest next start accepted the cycle after done (busy low in that cycle).
- Phase counter: one down-counter, width max($clog2 of SETTLE, WINDOW, TRAIN_CYCLES), reloaded on each state entry.

## Structure
- Package snn_seq_pkg: state enum, default parameter constants, count-width helper.
- Sub-module snn_argmax: combinational N_OUT-way compare with tie-to-lowest; registered by the sequencer in DONE.
- Sequencer: FSM + phase counter + N_OUT count registers.

## Test plan
- Reset then start, train_en=0, a_out=5'b00001 constant -> fp_clear at t+1, done at t+261, counts = {0,0,0,0,256}, class_idx=0, training_flag never high.
- a_out[3] high every cycle, a_out[1] high on alternate cycles -> count[3]=256, count[1]=128, class_idx=3.
- train_en=1 -> training_flag high exactly 256 cycles after SAMPLE, done at t+517.
- Equal counts on neurons 2 and 4 (a_out=5'b10100 constant) -> class_idx=2.
- abort at cycle 100 of SAMPLE -> IDLE next cycle, no done, class_valid=0; start while busy ignored.
- INIT asserted mid-TRAIN -> all outputs 0 immediately; next start runs full sequence normally.
